// File: rtl/apb_resp_pkg.sv
// apb_resp_pkg: shared FSM state type, register-index helpers and
// error-reason codes for the apb_reg_responder APB completer.
package apb_resp_pkg;

    // Responder FSM. SETUP is the cycle after the bus setup phase was seen,
    // ACCESS holds until the wait counter drains and the transfer completes.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Word index of the read-only identification register.
    localparam int ID_INDEX = 0;

    // Decode outcome of a captured transfer; anything but ERR_NONE
    // completes with PSLVERR and has no side effect.
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_RO    = 2'd3;

    // Bits needed to address nregs words (at least one bit).
    function automatic int idx_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/apb_resp_regfile.sv
// apb_resp_regfile: word register array behind apb_reg_responder.
// Index 0 is a constant ID word; indices 1..P_NUM_REGS-1 are storage with
// per-byte write enables. Reads are a combinational mux on idx.
module apb_resp_regfile
    import apb_resp_pkg::*;
#(
    parameter int                      P_DATA_WIDTH = 32,
    parameter int                      P_NUM_REGS   = 8,
    parameter logic [P_DATA_WIDTH-1:0] P_ID_VALUE   = 32'hA5B0_0001,
    parameter int                      P_IDX_WIDTH  = idx_width(P_NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [P_DATA_WIDTH/8-1:0] be,
    input  logic [P_IDX_WIDTH-1:0]    idx,
    input  logic [P_DATA_WIDTH-1:0]   wdata,
    output logic [P_DATA_WIDTH-1:0]   rdata
);

    localparam int NB = P_DATA_WIDTH / 8;

    // Index 0 has no storage: it is the constant ID word.
    logic [P_DATA_WIDTH-1:0] regs [1:P_NUM_REGS-1];

    // Storage update: byte lanes with be set take wdata on a write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < P_NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 1; i < P_NUM_REGS; i++) begin
                if (idx == P_IDX_WIDTH'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[b]) begin
                            regs[i][8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux: ID constant at index 0, stored word otherwise.
    always_comb begin
        rdata = '0;
        if (idx == P_IDX_WIDTH'(ID_INDEX)) begin
            rdata = P_ID_VALUE;
        end
        for (int i = 1; i < P_NUM_REGS; i++) begin
            if (idx == P_IDX_WIDTH'(i)) begin
                rdata = regs[i];
            end
        end
    end

endmodule

// File: rtl/apb_reg_responder.sv
// apb_reg_responder: APB completer in front of a small register file.
// Captures each transfer, inserts P_WAIT_CYCLES wait states in ACCESS,
// flags misaligned / out-of-range / ID-register writes with PSLVERR.
// Optional build macro APB_RESP_PSTRB_EN: honour I_PSTRB byte strobes on
// writes; without it every write updates the full word.
module apb_reg_responder
    import apb_resp_pkg::*;
#(
    parameter int                      P_ADDR_WIDTH  = 12,
    parameter int                      P_DATA_WIDTH  = 32,
    parameter int                      P_NUM_REGS    = 8,
    parameter int                      P_WAIT_CYCLES = 0,
    parameter logic [P_DATA_WIDTH-1:0] P_ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                      I_CLK,
    input  logic                      I_RESETn,
    input  logic                      I_PSEL,
    input  logic                      I_PENABLE,
    input  logic                      I_PWRITE,
    input  logic [P_ADDR_WIDTH-1:0]   I_PADDR,
    input  logic [P_DATA_WIDTH-1:0]   I_PWDATA,
    input  logic [P_DATA_WIDTH/8-1:0] I_PSTRB,
    output logic [P_DATA_WIDTH-1:0]   O_PRDATA,
    output logic                      O_PREADY,
    output logic                      O_PSLVERR
);

    localparam int NB = P_DATA_WIDTH / 8;
    localparam int IW = idx_width(P_NUM_REGS);
    localparam int WW = P_ADDR_WIDTH - 2;

    state_t                  state;
    logic [3:0]              cnt;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic                    wr_q;
    logic [P_DATA_WIDTH-1:0] wdata_q;
    logic [P_DATA_WIDTH-1:0] rdata_q;
    logic                    err_q;

    logic                    setup_seen;
    logic [WW-1:0]           widx;
    logic [1:0]              reason;
    logic                    rf_we;
    logic [NB-1:0]           be;
    logic [P_DATA_WIDTH-1:0] rf_rdata;

    // A bus setup phase is what starts a transfer from IDLE.
    assign setup_seen = I_PSEL && !I_PENABLE;

    // Decode the captured address into a word index and an error reason.
    always_comb begin
        widx   = addr_q[P_ADDR_WIDTH-1:2];
        reason = ERR_NONE;
        if (addr_q[1:0] != 2'b00) begin
            reason = ERR_ALIGN;
        end else if (int'(widx) >= P_NUM_REGS) begin
            reason = ERR_RANGE;
        end else if (wr_q && (int'(widx) == ID_INDEX)) begin
            reason = ERR_RO;
        end
    end

    // Transfer control: capture in IDLE, register read data into ACCESS,
    // count wait states, abort on PSEL drop, return to IDLE on completion.
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup_seen) begin
                        state   <= SETUP;
                        addr_q  <= I_PADDR;
                        wr_q    <= I_PWRITE;
                        wdata_q <= I_PWDATA;
                        cnt     <= 4'(P_WAIT_CYCLES);
                    end
                end
                SETUP: begin
                    if (!I_PSEL) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        state   <= ACCESS;
                        err_q   <= (reason != ERR_NONE);
                        rdata_q <= (wr_q || reason != ERR_NONE) ? '0 : rf_rdata;
                    end
                end
                ACCESS: begin
                    if (!I_PSEL) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (I_PENABLE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign O_PREADY  = (state == ACCESS) && (cnt == 4'd0);
    assign O_PRDATA  = O_PREADY ? rdata_q : '0;
    assign O_PSLVERR = O_PREADY && err_q;

    // Commit only on the completion edge of a clean write.
    assign rf_we = O_PREADY && I_PSEL && I_PENABLE && wr_q && !err_q;

`ifdef APB_RESP_PSTRB_EN
    logic [NB-1:0] strb_q;

    // Strobes are captured alongside the rest of the transfer.
    always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
            strb_q <= '0;
        end else if (state == IDLE && setup_seen) begin
            strb_q <= I_PSTRB;
        end
    end

    assign be = strb_q;
`else
    logic unused_pstrb;
    assign unused_pstrb = ^I_PSTRB;
    assign be = '1;
`endif

    apb_resp_regfile #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_NUM_REGS   (P_NUM_REGS),
        .P_ID_VALUE   (P_ID_VALUE),
        .P_IDX_WIDTH  (IW)
    ) u_regfile (
        .clk   (I_CLK),
        .rst_n (I_RESETn),
        .we    (rf_we),
        .be    (be),
        .idx   (widx[IW-1:0]),
        .wdata (wdata_q),
        .rdata (rf_rdata)
    );

endmodule

// File: tb/tb_apb_reg_responder.sv
// tb_apb_reg_responder: APB master driving two responders (0 and 3 wait
// states) with a reference register model and an expected-result queue.
module tb_apb_reg_responder;

    localparam logic [31:0] ID_VAL = 32'hA5B0_0001;

    logic        clk;
    logic        rst_n;
    logic        psel0, psel1, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        rd;
        int          waits;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem [2][8];

    apb_reg_responder #(.P_WAIT_CYCLES(0)) dut (
        .I_CLK(clk), .I_RESETn(rst_n), .I_PSEL(psel0), .I_PENABLE(penable),
        .I_PWRITE(pwrite), .I_PADDR(paddr), .I_PWDATA(pwdata), .I_PSTRB(pstrb),
        .O_PRDATA(prdata0), .O_PREADY(pready0), .O_PSLVERR(pslverr0)
    );

    apb_reg_responder #(.P_WAIT_CYCLES(3)) dut_w (
        .I_CLK(clk), .I_RESETn(rst_n), .I_PSEL(psel1), .I_PENABLE(penable),
        .I_PWRITE(pwrite), .I_PADDR(paddr), .I_PWDATA(pwdata), .I_PSTRB(pstrb),
        .O_PRDATA(prdata1), .O_PREADY(pready1), .O_PSLVERR(pslverr1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w != 0) ? pready1 : pready0;
    endfunction

    function automatic logic [31:0] rdat(input int w);
        return (w != 0) ? prdata1 : prdata0;
    endfunction

    function automatic logic serr(input int w);
        return (w != 0) ? pslverr1 : pslverr0;
    endfunction

    function automatic logic lane_on(input logic [3:0] s, input int b);
`ifdef APB_RESP_PSTRB_EN
        return s[b];
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: decides the response and applies clean writes.
    function automatic void predict(input int w, input logic wr, input logic [11:0] a,
                                    input logic [31:0] d, input logic [3:0] s,
                                    output logic [31:0] ed, output logic ee);
        int idx;
        idx = int'(a[11:2]);
        ee  = (a[1:0] != 2'b00) || (idx >= 8) || (wr && idx == 0);
        ed  = 32'h0;
        if (!ee) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_on(s, b)) mem[w][idx][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                ed = (idx == 0) ? ID_VAL : mem[w][idx];
            end
        end
    endfunction

    function automatic void clear_model();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 8; i++) mem[w][i] = 32'h0;
    endfunction

    // One APB transfer; entered and left at posedge+1 with the bus
    // released, so consecutive calls are back-to-back. The first PENABLE
    // cycle is the responder's SETUP state, so the expected count of
    // low-PREADY access cycles is 1 + P_WAIT_CYCLES.
    task automatic xfer(input int w, input logic wr, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s, input string tag);
        exp_t        e;
        logic [31:0] ed;
        logic        ee;
        int          waits;
        logic        leak;
        predict(w, wr, a, d, s, ed, ee);
        e.data  = ed;
        e.err   = ee;
        e.rd    = !wr;
        e.waits = (w != 0) ? 4 : 1;
        sbq.push_back(e);
        if (w != 0) psel1 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        leak  = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy(w)) break;
            if (rdat(w) != 32'h0 || serr(w)) leak = 1'b1;
            waits++;
            if (waits > 40) break;
        end
        e = sbq.pop_front();
        check({tag, "/waits"}, 32'(waits), 32'(e.waits));
        check({tag, "/pslverr"}, 32'(serr(w)), 32'(e.err));
        if (e.rd) check({tag, "/prdata"}, rdat(w), e.data);
        check({tag, "/quiet_while_waiting"}, 32'(leak), 32'h0);
        @(posedge clk); #1;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/pready0", 32'(pready0), 32'h0);
        check("rst/prdata0", prdata0, 32'h0);
        check("rst/pslverr0", 32'(pslverr0), 32'h0);
        check("rst/pready1", 32'(pready1), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Basic write/read, zero wait states
        xfer(0, 1'b1, 12'h004, 32'h1234_5678, 4'hF, "wr004");
        idle(1);
        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, "rd004");
        idle(1);

        // ID read with three wait states
        xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, "w3_rdid");
        idle(2);

        // Error responses and their lack of side effects
        xfer(0, 1'b1, 12'h000, 32'hDEAD_BEEF, 4'hF, "wr_id");
        xfer(0, 1'b1, 12'h002, 32'hDEAD_BEEF, 4'hF, "wr_unal");
        xfer(0, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'hF, "wr_range");
        xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, "rd_id");
        xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, "rd004_after_err");
        xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, "rd_range");
        xfer(0, 1'b0, 12'h006, 32'h0, 4'h0, "rd_unal");
        xfer(0, 1'b0, 12'hFFC, 32'h0, 4'h0, "rd_top");

        // Byte strobes
        xfer(0, 1'b1, 12'h008, 32'hFFFF_FFFF, 4'hF, "strb_fill");
        xfer(0, 1'b1, 12'h008, 32'h0000_0000, 4'b0101, "strb_0101");
        xfer(0, 1'b0, 12'h008, 32'h0, 4'hA, "strb_rd");
        xfer(0, 1'b1, 12'h008, 32'h1111_1111, 4'b0000, "strb_none");
        xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, "strb_rd2");

        // Back-to-back write then read, no idle in between
        xfer(0, 1'b1, 12'h00C, 32'hCAFE_F00D, 4'hF, "b2b_wr0");
        xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, "b2b_rd0");
        xfer(1, 1'b1, 12'h00C, 32'h0BAD_C0DE, 4'hF, "b2b_wr1");
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, "b2b_rd1");
        idle(1);

        // Mixed random traffic on both responders
        for (int k = 0; k < 24; k++) begin
            logic [11:0] a;
            a = 12'($urandom_range(0, 10) * 4);
            if ($urandom_range(0, 7) == 0) a = a | 12'h001;
            xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(0, 15)), "rand");
            idle($urandom_range(0, 1));
        end

        // PSEL dropped in the middle of a waited write: no commit
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h00C; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        psel1 = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort/pready", 32'(pready1), 32'h0);
        @(negedge clk);
        check("abort/pready_idle", 32'(pready1), 32'h0);
        @(posedge clk); #1;
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, "abort_rd");

        // Reset asserted in the middle of a read
        xfer(0, 1'b1, 12'h004, 32'hA5A5_5A5A, 4'hF, "pre_rst");
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst/pready_before", 32'(pready0), 32'h1);
        check("midrst/prdata_before", prdata0, mem[0][1]);
        rst_n = 1'b0;
        #1;
        check("midrst/pready", 32'(pready0), 32'h0);
        check("midrst/prdata", prdata0, 32'h0);
        check("midrst/pslverr", 32'(pslverr0), 32'h0);
        @(posedge clk); #1;
        psel0 = 1'b0; penable = 1'b0;
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 12'(i * 4), 32'h0, 4'h0, "post_rst0");
        end
        xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, "post_rst1");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
